// File: rtl/nn_pkg.sv
// Shared constants and types for the network output stage and its argmax classifier.
package nn_pkg;

  localparam int NEURONS_OUT = 10;
  localparam int DATA_WIDTH  = 16;
  localparam int IDX_WIDTH   = $clog2(NEURONS_OUT);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } argmax_state_t;

endpackage

// File: rtl/output_argmax.sv
// Serial argmax over the output-layer activations: captures a vector, then walks it
// one element per clock with a single comparator and reports the winning index/value.
module output_argmax
  import nn_pkg::*;
#(
  parameter int neurons   = NEURONS_OUT,
  parameter int dataWidth = DATA_WIDTH,
  parameter int idxWidth  = $clog2(neurons)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           argmax_in_valid,
  input  logic [neurons*dataWidth-1:0]   argmax_in_data,
  output logic                           argmax_busy,
  output logic                           argmax_out_valid,
  output logic [idxWidth-1:0]            argmax_out_digit,
  output logic [dataWidth-1:0]           argmax_out_max,
  output logic                           argmax_overrun
);

  localparam logic [idxWidth-1:0] LAST_IDX = idxWidth'(neurons - 1);
  localparam logic [idxWidth-1:0] ONE_IDX  = idxWidth'(1);

  argmax_state_t          state_r, state_s;
  logic [dataWidth-1:0]   elem_r [neurons];
  logic [dataWidth-1:0]   elem_s [neurons];
  logic [idxWidth-1:0]    ptr_r, ptr_s;
  logic [dataWidth-1:0]   best_val_r, best_val_s;
  logic [idxWidth-1:0]    best_idx_r, best_idx_s;
  logic                   busy_r, busy_s;
  logic                   out_valid_r, out_valid_s;
  logic [idxWidth-1:0]    digit_r, digit_s;
  logic [dataWidth-1:0]   max_r, max_s;
  logic                   overrun_r, overrun_s;

  logic [dataWidth-1:0]   cur_elem_s;
  logic [dataWidth-1:0]   win_val_s;
  logic [idxWidth-1:0]    win_idx_s;

  // Single comparator/mux: strict greater-than so ties keep the lower index.
  always_comb begin
    cur_elem_s = elem_r[ptr_r];
    if (cur_elem_s > best_val_r) begin
      win_val_s = cur_elem_s;
      win_idx_s = ptr_r;
    end else begin
      win_val_s = best_val_r;
      win_idx_s = best_idx_r;
    end
  end

  // Next-state and next-output logic for the capture/scan FSM.
  always_comb begin
    state_s     = state_r;
    elem_s      = elem_r;
    ptr_s       = ptr_r;
    best_val_s  = best_val_r;
    best_idx_s  = best_idx_r;
    busy_s      = busy_r;
    out_valid_s = 1'b0;
    digit_s     = digit_r;
    max_s       = max_r;
    overrun_s   = overrun_r;

    case (state_r)
      IDLE: begin
        if (argmax_in_valid) begin
          for (int i = 0; i < neurons; i++) begin
            elem_s[i] = argmax_in_data[i*dataWidth +: dataWidth];
          end
          best_val_s = argmax_in_data[dataWidth-1:0];
          best_idx_s = '0;
          ptr_s      = ONE_IDX;
          busy_s     = 1'b1;
          state_s    = SCAN;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        // A strobe while scanning is dropped; the scan itself carries on.
        if (argmax_in_valid) begin
          overrun_s = 1'b1;
        end else begin
          overrun_s = overrun_r;
        end
        best_val_s = win_val_s;
        best_idx_s = win_idx_s;
        if (ptr_r == LAST_IDX) begin
          digit_s     = win_idx_s;
          max_s       = win_val_s;
          out_valid_s = 1'b1;
          busy_s      = 1'b0;
          ptr_s       = '0;
          state_s     = IDLE;
        end else begin
          ptr_s   = ptr_r + ONE_IDX;
          state_s = SCAN;
        end
      end
      default: begin
        busy_s  = 1'b0;
        ptr_s   = '0;
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      elem_r      <= '{default: '0};
      ptr_r       <= '0;
      best_val_r  <= '0;
      best_idx_r  <= '0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      digit_r     <= '0;
      max_r       <= '0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      elem_r      <= elem_s;
      ptr_r       <= ptr_s;
      best_val_r  <= best_val_s;
      best_idx_r  <= best_idx_s;
      busy_r      <= busy_s;
      out_valid_r <= out_valid_s;
      digit_r     <= digit_s;
      max_r       <= max_s;
      overrun_r   <= overrun_s;
    end
  end

  assign argmax_busy      = busy_r;
  assign argmax_out_valid = out_valid_r;
  assign argmax_out_digit = digit_r;
  assign argmax_out_max   = max_r;
  assign argmax_overrun   = overrun_r;

endmodule

// File: tb/tb_output_argmax.sv
// Self-checking bench for output_argmax: directed table, corner sequences, random vectors.
module tb_output_argmax;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int IW = 4;

  logic              clk;
  logic              rst_n;
  logic              argmax_in_valid;
  logic [N*DW-1:0]   argmax_in_data;
  logic              argmax_busy;
  logic              argmax_out_valid;
  logic [IW-1:0]     argmax_out_digit;
  logic [DW-1:0]     argmax_out_max;
  logic              argmax_overrun;

  int total = 0;
  int bad   = 0;

  output_argmax dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .argmax_in_valid  (argmax_in_valid),
    .argmax_in_data   (argmax_in_data),
    .argmax_busy      (argmax_busy),
    .argmax_out_valid (argmax_out_valid),
    .argmax_out_digit (argmax_out_digit),
    .argmax_out_max   (argmax_out_max),
    .argmax_overrun   (argmax_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [N*DW-1:0] data;
    logic [IW-1:0]   digit;
    logic [DW-1:0]   maxv;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] mkvec(input logic [DW-1:0] fill,
                                            input int i1, input logic [DW-1:0] v1,
                                            input int i2, input logic [DW-1:0] v2,
                                            input int i3, input logic [DW-1:0] v3);
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = fill;
    if (i1 >= 0) d[i1*DW +: DW] = v1;
    if (i2 >= 0) d[i2*DW +: DW] = v2;
    if (i3 >= 0) d[i3*DW +: DW] = v3;
    return d;
  endfunction

  // Reference: find the maximum value, then the first position holding it.
  task automatic ref_model(input logic [N*DW-1:0] d, output logic [IW-1:0] dig,
                           output logic [DW-1:0] mx);
    int m;
    m = 0;
    for (int i = 0; i < N; i++)
      if (int'(d[i*DW +: DW]) > m) m = int'(d[i*DW +: DW]);
    mx = DW'(m);
    dig = '0;
    for (int i = N - 1; i >= 0; i--)
      if (int'(d[i*DW +: DW]) == m) dig = IW'(i);
  endtask

  // Drive a one-cycle strobe; returns at the falling edge after the capture edge.
  task automatic strobe(input logic [N*DW-1:0] d);
    argmax_in_valid = 1'b1;
    argmax_in_data  = d;
    @(negedge clk);
    argmax_in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; k0 = clocks already elapsed since capture.
  task automatic wait_result(input string nm, input int k0, input logic [IW-1:0] d,
                             input logic [DW-1:0] m, input logic ov);
    int  k;
    bit  seen;
    k = k0;
    seen = 1'b0;
    while (k < 30 && !seen) begin
      @(negedge clk);
      k++;
      if (k == 1) chk({nm, " busy_mid"}, 32'(argmax_busy), 32'd1);
      if (argmax_out_valid) seen = 1'b1;
    end
    chk({nm, " latency"}, 32'(k), 32'd9);
    chk({nm, " digit"}, 32'(argmax_out_digit), 32'(d));
    chk({nm, " max"}, 32'(argmax_out_max), 32'(m));
    chk({nm, " overrun"}, 32'(argmax_overrun), 32'(ov));
    chk({nm, " busy_end"}, 32'(argmax_busy), 32'd0);
  endtask

  task automatic run_vec(input string nm, input logic [N*DW-1:0] dv, input logic ov);
    logic [IW-1:0] d;
    logic [DW-1:0] m;
    ref_model(dv, d, m);
    strobe(dv);
    wait_result(nm, 0, d, m, ov);
    @(negedge clk);
    chk({nm, " pulse_len"}, 32'(argmax_out_valid), 32'd0);
  endtask

  initial begin
    logic [IW-1:0]   ed;
    logic [DW-1:0]   em;
    logic [N*DW-1:0] va, vb;
    int              nvalid;

    tbl[0] = '{"single_max", mkvec(16'h0050, 0, 16'h0100, 1, 16'h0200, 7, 16'h7F00), 4'd7, 16'h7F00};
    tbl[1] = '{"tie_ffff",   mkvec(16'h0000, 2, 16'hFFFF, 5, 16'hFFFF, -1, 16'h0000), 4'd2, 16'hFFFF};
    tbl[2] = '{"all_zero",   mkvec(16'h0000, -1, 16'h0000, -1, 16'h0000, -1, 16'h0000), 4'd0, 16'h0000};
    tbl[3] = '{"last_only",  mkvec(16'h0000, 9, 16'h0001, -1, 16'h0000, -1, 16'h0000), 4'd9, 16'h0001};
    tbl[4] = '{"first_only", mkvec(16'h0000, 0, 16'h1234, -1, 16'h0000, -1, 16'h0000), 4'd0, 16'h1234};
    tbl[5] = '{"tie_ends",   mkvec(16'h8000, 0, 16'hFFFF, 9, 16'hFFFF, -1, 16'h0000), 4'd0, 16'hFFFF};

    rst_n = 1'b0;
    argmax_in_valid = 1'b0;
    argmax_in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(argmax_busy), 32'd0);
    chk("rst out_valid", 32'(argmax_out_valid), 32'd0);
    chk("rst digit", 32'(argmax_out_digit), 32'd0);
    chk("rst max", 32'(argmax_out_max), 32'd0);
    chk("rst overrun", 32'(argmax_overrun), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      strobe(tbl[t].data);
      wait_result(tbl[t].name, 0, tbl[t].digit, tbl[t].maxv, 1'b0);
      @(negedge clk);
      chk({tbl[t].name, " pulse_len"}, 32'(argmax_out_valid), 32'd0);
    end

    // Bus changes right after capture must not affect the result.
    va = tbl[0].data;
    vb = mkvec(16'h0000, 3, 16'hFFFF, -1, 16'h0000, -1, 16'h0000);
    strobe(va);
    argmax_in_data = vb;
    wait_result("bus_change", 0, 4'd7, 16'h7F00, 1'b0);
    @(negedge clk);

    // Second strobe in the out_valid cycle is accepted.
    strobe(tbl[1].data);
    wait_result("b2b_first", 0, 4'd2, 16'hFFFF, 1'b0);
    strobe(tbl[3].data);
    wait_result("b2b_second", 0, 4'd9, 16'h0001, 1'b0);
    @(negedge clk);

    for (int r = 0; r < 25; r++) begin
      va = '0;
      for (int i = 0; i < N; i++)
        va[i*DW +: DW] = (r % 2 == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
      run_vec($sformatf("rand%0d", r), va, 1'b0);
    end

    // Strobe while busy: dropped, overrun set, first result intact.
    va = tbl[0].data;
    strobe(va);
    @(negedge clk);
    @(negedge clk);
    argmax_in_valid = 1'b1;
    argmax_in_data  = tbl[1].data;
    @(negedge clk);
    argmax_in_valid = 1'b0;
    wait_result("overrun_scan", 3, 4'd7, 16'h7F00, 1'b1);
    @(negedge clk);
    run_vec("overrun_sticky", tbl[4].data, 1'b1);

    // Reset mid-scan abandons silently.
    strobe(tbl[1].data);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst busy", 32'(argmax_busy), 32'd0);
    chk("midrst out_valid", 32'(argmax_out_valid), 32'd0);
    chk("midrst digit", 32'(argmax_out_digit), 32'd0);
    chk("midrst max", 32'(argmax_out_max), 32'd0);
    chk("midrst overrun", 32'(argmax_overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (argmax_out_valid) nvalid++;
    end
    chk("midrst no_valid", 32'(nvalid), 32'd0);
    ref_model(tbl[0].data, ed, em);
    strobe(tbl[0].data);
    wait_result("after_rst", 0, ed, em, 1'b0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/output_argmax.md
Name: output_argmax

Overview:
- Classification stage directly downstream of the output layer. Consumes its packed vector of `neurons` sigmoid activations and its valid strobe.
- Latches the vector and scans it serially, one comparison per clock, to find the largest activation.
- Reports the winning index (the recognised digit 0-9) plus its activation, with a one-cycle valid pulse.
- Serial scan keeps area to one comparator and one mux.

Parameters:
- neurons, 10, number of activations in the input vector; legal range >= 2.
- dataWidth, 16, width of each activation; treated as unsigned (sigmoid outputs are non-negative).
- idxWidth, $clog2(neurons), width of the digit index output (4 at default).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- argmax_in_valid  input  1  one-cycle strobe; argmax_in_data is valid this cycle.
- argmax_in_data  input  neurons*dataWidth  packed activations; element i at [i*dataWidth +: dataWidth].
- argmax_busy  output  1  high while a scan is in progress; new input is not accepted.
- argmax_out_valid  output  1  one-cycle pulse; result outputs are updated this cycle.
- argmax_out_digit  output  idxWidth  index of the maximum activation.
- argmax_out_max  output  dataWidth  value of the maximum activation.
- argmax_overrun  output  1  sticky flag: an input strobe arrived while busy and was dropped.

Behaviour:
- Reset (rst_n low at a rising edge):
  - State goes to IDLE.
  - All outputs go to 0: busy, out_valid, digit, max, overrun.
  - The capture register and scan pointer are cleared.
  - A reset during SCAN abandons the scan silently; no out_valid is produced.
- States: IDLE, SCAN.
- IDLE with in_valid=1 at edge E0:
  - Capture the full vector into an internal register.
  - best_val <= element 0, best_idx <= 0, ptr <= 1.
  - State -> SCAN, busy <= 1.
- IDLE with in_valid=0: hold; result outputs keep their last values.
- SCAN, each edge:
  - If element[ptr] > best_val (strictly greater, unsigned), then best_val <= element[ptr] and best_idx <= ptr.
  - Ties keep the lower index.
  - If ptr != neurons-1: ptr <= ptr+1.
- SCAN, final compare (ptr == neurons-1):
  - Compare element[ptr] against best_val as above.
  - digit and max <= the post-compare winner.
  - out_valid <= 1 for exactly one cycle.
  - busy <= 0, state -> IDLE.
- Latency: out_valid is high in the cycle after edge E(neurons-1). That is neurons-1 clocks after the capture edge (9 at default).
- Maximum throughput: one vector per neurons clocks. The earliest next accept is the edge at which out_valid is high.
- in_valid while busy=1 (including the final-compare cycle):
  - The input is dropped.
  - overrun <= 1 and stays set until reset.
  - The scan in progress is unaffected.
- in_valid in the same cycle that out_valid is high: state is IDLE, so the input is accepted normally.
- The input data bus is sampled only on the capture edge; changes during SCAN have no effect.
- All outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Shared package nn_pkg holds:
  - Constants NEURONS_OUT=10 and DATA_WIDTH=16, also used by the output layer.
  - Localparam IDX_WIDTH.
  - Typedef argmax_state_t {IDLE, SCAN}.
- No sub-module. The comparator/mux is a few lines inline; the FSM, pointer and capture register live in output_argmax.

Test Plan:
- Single max: elements = {0x0100, 0x0200, 0x7F00 at idx 7, others 0x0050}. Strobe once. Expect out_valid exactly 9 cycles later, digit=7, max=0x7F00, overrun=0.
- Tie and extremes: idx 2 and idx 5 both 0xFFFF, others 0x0000. Expect digit=2, max=0xFFFF (lower index wins, full-scale unsigned compare). All-zero vector: expect digit=0, max=0x0000.
- Max at boundaries:
  - Only idx 9 = 0x0001, rest 0. Expect digit=9, max=0x0001 (last element compared).
  - Only idx 0 nonzero. Expect digit=0.
- Back-to-back:
  - Second strobe in the out_valid cycle: accepted, second result 9 cycles later.
  - Second strobe 3 cycles after the first: dropped, overrun=1, first result correct.
  - Overrun remains 1 through a later clean transaction.
- Reset mid-scan: rst_n low 4 cycles after the strobe. Expect busy=0, all outputs 0, no out_valid. A fresh strobe after release gives the correct result with normal latency.
- Data bus change during SCAN: drive a different vector on the cycle after capture. Expect the result to reflect only the captured vector.
